// File: rtl/cond_logic_if.sv
// Decoder-side control bundle for the conditional-execution block.
// The master drives the decoded instruction fields; the slave returns the
// gated write strobes, the condition result and the architectural flags.
interface cond_logic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition field
// against the registered {N,Z,C,V} flags, gates the decoder write requests,
// and updates the two flag groups (N,Z and C,V) independently.
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       n_f;
    logic       z_f;
    logic       c_f;
    logic       v_f;
    logic       commit;

    assign n_f = flags_q[3];
    assign z_f = flags_q[2];
    assign c_f = flags_q[1];
    assign v_f = flags_q[0];

    // Condition decode uses only the registered flags, so an instruction
    // never observes the flags it is itself producing.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // A write of any kind is only allowed when the condition passes and the
    // pipeline is neither stalled nor in reset.
    assign commit       = cond_ex & ~bus.stall & ~reset;

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS  & commit;
    assign bus.RegWrite = bus.RegW & commit;
    assign bus.MemWrite = bus.MemW & commit;
    assign bus.Flags    = flags_q;

    // Flag register: reset clears both groups; otherwise each group loads
    // from the ALU only when its own write-enable bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (bus.FlagW[1] && commit) begin
                flags_q[3:2] <= bus.ALUFlags[3:2];
            end
            if (bus.FlagW[0] && commit) begin
                flags_q[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL use one clock and one reset: clock `clk`, reset `reset`; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk edge.
REQ-004 Cond  input  4  instruction condition field (bits 31:28).
REQ-005 ALUFlags  input  4  current ALU result flags, order {N,Z,C,V}.
REQ-006 FlagW  input  2  flag-write request from decoder: bit1 = N,Z; bit0 = C,V.
REQ-007 PCS  input  1  decoder request to write PC (branch or Rd=15).
REQ-008 RegW  input  1  decoder register-write request.
REQ-009 MemW  input  1  decoder memory-write request.
REQ-010 stall  input  1  hold request: suppresses all architectural effects this cycle.
REQ-011 PCSrc  output  1  gated PC write.
REQ-012 RegWrite  output  1  gated register write.
REQ-013 MemWrite  output  1  gated memory write.
REQ-014 CondEx  output  1  condition-passed indicator for the current instruction.
REQ-015 Flags  output  4  registered architectural flags {N,Z,C,V}.

Function
REQ-016 CondEx SHALL be combinational from Cond and registered Flags (never from ALUFlags); N=Flags[3], Z=Flags[2], C=Flags[1], V=Flags[0].
REQ-017 Condition table SHALL be: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0 (reserved, never executes).
REQ-018 PCSrc = PCS&CondEx&!stall&!reset; RegWrite = RegW&CondEx&!stall&!reset; MemWrite = MemW&CondEx&!stall&!reset; all combinational, zero latency.
REQ-019 Flags[3:2] SHALL load ALUFlags[3:2] on the rising edge when FlagW[1]&CondEx&!stall&!reset; otherwise hold.
REQ-020 Flags[1:0] SHALL load ALUFlags[1:0] on the rising edge when FlagW[0]&CondEx&!stall&!reset; otherwise hold.
REQ-021 The two flag groups SHALL update independently; FlagW=10 SHALL leave C,V unchanged and FlagW=01 SHALL leave N,Z unchanged.
REQ-022 Flag update latency SHALL be one cycle: an instruction sees flags written by the preceding instruction, never its own.
REQ-023 A failed condition (CondEx=0) SHALL suppress flag writes and all three write outputs in the same cycle.
REQ-024 stall=1 SHALL hold Flags and force all write outputs to 0 regardless of Cond; CondEx SHALL still reflect the table.
REQ-025 Cond=1111 SHALL behave as never-execute: no flag update, all write outputs 0.

Reset
REQ-026 On a rising edge with reset=1, Flags SHALL become 0000 regardless of FlagW, CondEx or stall.
REQ-027 While reset=1, PCSrc, RegWrite and MemWrite SHALL be 0.
REQ-028 Reset asserted mid-sequence SHALL discard any pending flag write in that cycle; the first instruction after reset SHALL evaluate against Flags=0000.

Verification
REQ-029 Reset, then Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0; Cond=1110, RegW=1 -> RegWrite=1.
REQ-030 Cond=1110, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100; then Cond=0000, PCS=1 -> PCSrc=1; Cond=0001, PCS=1 -> PCSrc=0.
REQ-031 Flags=0100, Cond=1110, FlagW=01, ALUFlags=1011 -> Flags=0111 (N,Z held, C,V loaded).
REQ-032 Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111 -> CondEx=0, Flags stays 0000, MemWrite=0 with MemW=1.
REQ-033 Cond=1110, FlagW=11, ALUFlags=1001, stall=1 -> Flags unchanged, all write outputs 0; same inputs with stall=0 -> Flags=1001, then Cond=1011 (LT) -> CondEx=0, Cond=1010 (GE) -> CondEx=1.
REQ-034 Sweep all 16 Cond codes against all 16 Flags values -> CondEx matches REQ-017 table in every case; Cond=1111 -> CondEx=0 always.
